// File: rtl/mii_rx_framer_pkg.sv
// Shared definitions for the MII receive path: FSM state encoding,
// CRC-32 constants and the preamble/SFD byte values.
package mii_rx_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } rx_state_t;

  // Reflected CRC-32 (IEEE 802.3), register not inverted in hardware.
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  // Register value after running data plus its own FCS through the CRC.
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/mii_crc32.sv
// Combinational byte-wise reflected CRC-32 step: crc_out is the register
// value after shifting in one byte, LSB first. Shared with the TX side.
module mii_crc32
  import mii_rx_framer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // stage[k] is the register after k data bits have been absorbed.
  logic [31:0] stage [9];

  assign stage[0] = crc_in ^ {24'h000000, data};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit
      assign stage[gi+1] = stage[gi][0] ? ((stage[gi] >> 1) ^ CRC32_POLY)
                                        : (stage[gi] >> 1);
    end
  endgenerate

  assign crc_out = stage[8];

endmodule

// File: rtl/mii_rx_framer.sv
// MII receive framer: strips preamble/SFD from the assembled byte stream,
// delays bytes through a small hold buffer so the last byte can carry eof,
// counts frame length and checks the CRC-32 residue.
// Build option: define MII_RX_STRIP_FCS_EN to drop the 4 FCS bytes from the
// output stream (eof then rides on the last payload byte).
module mii_rx_framer
  import mii_rx_framer_pkg::*;
#(
  parameter int MIN_PRE = 2,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 11
) (
  input  logic             mii_clk,
  input  logic             reset,
  input  logic             in_rdy,
  input  logic [7:0]       in_d,
  input  logic             mii_en,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic [LEN_W-1:0] frame_len
);

  // Hold depth: one byte so eof can be attached to the final byte; with FCS
  // stripping, four FCS candidates sit behind that pending byte, so the byte
  // at the head is always the last payload byte when the frame ends.
`ifdef MII_RX_STRIP_FCS_EN
  localparam int HOLD_D = 5;
`else
  localparam int HOLD_D = 1;
`endif

  localparam logic [2:0]  HOLD_CNT_FULL = 3'(HOLD_D);
  localparam logic [7:0]  MIN_PRE_C     = 8'(MIN_PRE);
  localparam logic [31:0] MIN_LEN_C     = 32'(MIN_LEN);
  localparam logic [31:0] MAX_LEN_C     = 32'(MAX_LEN);

  rx_state_t        state_reg, state_next;
  logic [7:0]       pre_cnt_reg, pre_cnt_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [31:0]      crc_reg, crc_next, crc_upd;
  logic [2:0]       hold_cnt_reg, hold_cnt_next;
  logic             first_reg, first_next;
  logic [7:0]       hold_reg   [HOLD_D];
  logic [7:0]       hold_shift [HOLD_D];

  logic             out_valid_reg, out_valid_next;
  logic [7:0]       out_data_reg, out_data_next;
  logic             out_sof_reg, out_sof_next;
  logic             out_eof_reg, out_eof_next;
  logic             out_err_reg, out_err_next;
  logic [LEN_W-1:0] frame_len_reg, frame_len_next;

  logic             accept;
  logic             end_cond;
  logic             hold_full;
  logic             frame_bad;
  logic [31:0]      len_wide;

  mii_crc32 u_crc (
    .crc_in  (crc_reg),
    .data    (in_d),
    .crc_out (crc_upd)
  );

  // Frame ends on the first idle cycle with RX_DV low; a byte strobe with
  // RX_DV already low is the trailing byte and still belongs to the frame.
  assign end_cond  = !mii_en && !in_rdy;
  assign hold_full = (hold_cnt_reg == HOLD_CNT_FULL);
  assign len_wide  = 32'(len_reg);
  assign frame_bad = (crc_reg != CRC32_RESIDUE) ||
                     (len_wide < MIN_LEN_C) || (len_wide > MAX_LEN_C);

  // Shift path of the hold buffer: new byte enters at the tail, head is oldest.
  genvar gi;
  generate
    for (gi = 0; gi < HOLD_D; gi++) begin : g_hold
      if (gi == HOLD_D - 1) begin : g_tail
        assign hold_shift[gi] = in_d;
      end else begin : g_body
        assign hold_shift[gi] = hold_reg[gi+1];
      end
    end
  endgenerate

  // Next-state, datapath and output decode.
  always_comb begin
    state_next     = state_reg;
    pre_cnt_next   = pre_cnt_reg;
    len_next       = len_reg;
    crc_next       = crc_reg;
    hold_cnt_next  = hold_cnt_reg;
    first_next     = first_reg;
    accept         = 1'b0;
    out_valid_next = 1'b0;
    out_data_next  = out_data_reg;
    out_sof_next   = 1'b0;
    out_eof_next   = 1'b0;
    out_err_next   = 1'b0;
    frame_len_next = frame_len_reg;

    case (state_reg)
      ST_IDLE: begin
        if (in_rdy && (in_d == PREAMBLE_BYTE)) begin
          state_next   = ST_PRE;
          pre_cnt_next = 8'd1;
        end
      end

      ST_PRE: begin
        if (in_rdy) begin
          if (in_d == PREAMBLE_BYTE) begin
            if (pre_cnt_reg != 8'hFF) begin
              pre_cnt_next = pre_cnt_reg + 8'd1;
            end
          end else if ((in_d == SFD_BYTE) && (pre_cnt_reg >= MIN_PRE_C)) begin
            state_next    = ST_DATA;
            crc_next      = CRC32_INIT;
            len_next      = '0;
            hold_cnt_next = 3'd0;
            first_next    = 1'b1;
          end else begin
            state_next = ST_DROP;
          end
        end else if (end_cond) begin
          state_next = ST_IDLE;
        end
      end

      ST_DATA: begin
        if (in_rdy) begin
          accept   = 1'b1;
          crc_next = crc_upd;
          if (len_reg != '1) begin
            len_next = len_reg + 1'b1;
          end
          if (hold_full) begin
            // Head byte is now known not to be the last one.
            out_valid_next = 1'b1;
            out_data_next  = hold_reg[0];
            out_sof_next   = first_reg;
            first_next     = 1'b0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 3'd1;
          end
        end else if (end_cond) begin
          state_next    = ST_IDLE;
          hold_cnt_next = 3'd0;
          first_next    = 1'b0;
          if (hold_full) begin
            out_valid_next = 1'b1;
            out_data_next  = hold_reg[0];
            out_sof_next   = first_reg;
            out_eof_next   = 1'b1;
            out_err_next   = frame_bad;
            frame_len_next = len_reg;
          end else if (hold_cnt_reg != 3'd0) begin
            // Too short to hold any payload past the FCS: still close the
            // frame toward the consumer, flagged as an error.
            out_valid_next = 1'b1;
            out_data_next  = 8'h00;
            out_sof_next   = 1'b1;
            out_eof_next   = 1'b1;
            out_err_next   = 1'b1;
            frame_len_next = len_reg;
          end
        end
      end

      ST_DROP: begin
        if (end_cond) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge mii_clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame bookkeeping: preamble count, length, CRC, hold occupancy.
  always_ff @(posedge mii_clk) begin
    if (reset) begin
      pre_cnt_reg  <= '0;
      len_reg      <= '0;
      crc_reg      <= CRC32_INIT;
      hold_cnt_reg <= '0;
      first_reg    <= 1'b0;
    end else begin
      pre_cnt_reg  <= pre_cnt_next;
      len_reg      <= len_next;
      crc_reg      <= crc_next;
      hold_cnt_reg <= hold_cnt_next;
      first_reg    <= first_next;
    end
  end

  // Hold buffer storage; shifts once per accepted data byte.
  always_ff @(posedge mii_clk) begin
    if (reset) begin
      for (int i = 0; i < HOLD_D; i++) begin
        hold_reg[i] <= '0;
      end
    end else if (accept) begin
      hold_reg <= hold_shift;
    end
  end

  // Registered output stage toward the receive FIFO.
  always_ff @(posedge mii_clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sof_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
      out_err_reg   <= 1'b0;
      frame_len_reg <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_sof_reg   <= out_sof_next;
      out_eof_reg   <= out_eof_next;
      out_err_reg   <= out_err_next;
      frame_len_reg <= frame_len_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sof   = out_sof_reg;
  assign out_eof   = out_eof_reg;
  assign out_err   = out_err_reg;
  assign frame_len = frame_len_reg;

endmodule

// File: tb/tb_mii_rx_framer.sv
// Self-checking bench for mii_rx_framer: frames are built with a bench-side
// CRC, expected output bytes are queued as each frame is driven, and output
// pulses collected from the DUT are compared against that queue.
module tb_mii_rx_framer;

  localparam int LEN_W = 11;
`ifdef MII_RX_STRIP_FCS_EN
  localparam int HOLD_D = 5;
`else
  localparam int HOLD_D = 1;
`endif

  logic             mii_clk = 1'b0;
  logic             reset;
  logic             in_rdy;
  logic [7:0]       in_d;
  logic             mii_en;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_sof;
  logic             out_eof;
  logic             out_err;
  logic [LEN_W-1:0] frame_len;

  typedef struct {
    logic [7:0]       d;
    logic             sof;
    logic             eof;
    logic             err;
    logic [LEN_W-1:0] len;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       obs_q[$];
  logic [7:0] frm[$];
  int         cmp_count  = 0;
  int         fail_count = 0;

  mii_rx_framer #(
    .MIN_PRE (2),
    .MIN_LEN (64),
    .MAX_LEN (1518),
    .LEN_W   (LEN_W)
  ) dut (
    .mii_clk   (mii_clk),
    .reset     (reset),
    .in_rdy    (in_rdy),
    .in_d      (in_d),
    .mii_en    (mii_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_err   (out_err),
    .frame_len (frame_len)
  );

  always #5 mii_clk = ~mii_clk;

  // Collect every output pulse, sampled on the falling edge.
  always @(negedge mii_clk) begin
    if (out_valid === 1'b1) begin
      obs_q.push_back('{out_data, out_sof, out_eof, out_err, frame_len});
    end
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h000000, b};
    for (int k = 0; k < 8; k++) begin
      if (c[0]) c = (c >> 1) ^ 32'hEDB88320;
      else      c = c >> 1;
    end
    return c;
  endfunction

  // Random payload followed by its FCS (complemented CRC, LSB byte first).
  task automatic build_frame(input int n_payload);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n_payload; i++) begin
      b = 8'($urandom_range(0, 255));
      frm.push_back(b);
      c = crc_step(c, b);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic build_raw(input int n);
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  // One assembled byte every two clocks; called and returns at posedge+1.
  task automatic drive_byte(input logic [7:0] b, input logic en);
    in_rdy = 1'b1;
    in_d   = b;
    mii_en = en;
    @(posedge mii_clk); #1;
    in_rdy = 1'b0;
    mii_en = en;
    @(posedge mii_clk); #1;
  endtask

  // Preamble, start byte, then frm; the last byte trails RX_DV.
  task automatic send_frame(input int npre, input logic [7:0] sfd);
    for (int i = 0; i < npre; i++) drive_byte(8'h55, 1'b1);
    drive_byte(sfd, frm.size() != 0);
    for (int i = 0; i < frm.size(); i++) drive_byte(frm[i], i != frm.size() - 1);
    mii_en = 1'b0;
  endtask

  task automatic idle(input int n);
    in_rdy = 1'b0;
    mii_en = 1'b0;
    repeat (n) begin
      @(posedge mii_clk); #1;
    end
  endtask

  // Queue the pulses the framer should produce for frm.
  task automatic expect_frame(input logic bad_crc);
    int               n;
    logic             err;
    logic [LEN_W-1:0] len;
    n   = frm.size();
    len = (n > 2047) ? '1 : LEN_W'(n);
    err = bad_crc || (n < 64) || (n > 1518);
`ifdef MII_RX_STRIP_FCS_EN
    if (n < 5) exp_q.push_back('{8'h00, 1'b1, 1'b1, 1'b1, len});
    else for (int i = 0; i < n - 4; i++) exp_q.push_back('{frm[i], i == 0, i == n - 5, err, len});
`else
    for (int i = 0; i < n; i++) exp_q.push_back('{frm[i], i == 0, i == n - 1, err, len});
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1; in_rdy = 1'b0; in_d = 8'h00; mii_en = 1'b0;
    repeat (3) @(posedge mii_clk);
    #1;
    cmp_count++;
    if ({out_valid, out_data, out_sof, out_eof, out_err, frame_len} !== '0) begin
      fail_count++;
      $display("FAIL reset_outputs: got valid=%b data=%h sof=%b eof=%b err=%b len=%0d, expected all 0",
               out_valid, out_data, out_sof, out_eof, out_err, frame_len);
    end
    reset = 1'b0;
    idle(3);
    cmp_count++;
    if (obs_q.size() !== 0) begin
      fail_count++;
      $display("FAIL reset_quiet: got %0d pulses, expected 0", obs_q.size());
    end
    obs_q.delete();
    $display("reset: done");
  endtask

  task automatic test_good_frame();
    rec_t e, o;
    build_frame(60);
    expect_frame(1'b0);
    send_frame(7, 8'hD5);
    idle(4);
    $display("good_frame: %0d bytes in, %0d pulses out", frm.size(), obs_q.size());
    cmp_count++;
    if (obs_q.size() !== exp_q.size()) begin
      fail_count++;
      $display("FAIL good_frame count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); cmp_count++;
      if (o.d !== e.d || o.sof !== e.sof || o.eof !== e.eof || (e.eof && (o.err !== e.err || o.len !== e.len))) begin
        fail_count++;
        $display("FAIL good_frame byte: got d=%h sof=%b eof=%b err=%b len=%0d, expected d=%h sof=%b eof=%b err=%b len=%0d",
                 o.d, o.sof, o.eof, o.err, o.len, e.d, e.sof, e.eof, e.err, e.len);
      end
    end
    exp_q.delete(); obs_q.delete();
    cmp_count++;
    if (frame_len !== 11'd64 || out_valid !== 1'b0) begin
      fail_count++;
      $display("FAIL good_frame hold: got frame_len=%0d valid=%b, expected 64 and 0", frame_len, out_valid);
    end
  endtask

  task automatic test_bad_crc();
    rec_t e, o;
    build_frame(60);
    frm[10] = frm[10] ^ 8'h04;
    expect_frame(1'b1);
    send_frame(7, 8'hD5);
    idle(4);
    $display("bad_crc: %0d bytes in, %0d pulses out", frm.size(), obs_q.size());
    cmp_count++;
    if (obs_q.size() !== exp_q.size()) begin
      fail_count++;
      $display("FAIL bad_crc count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); cmp_count++;
      if (o.d !== e.d || o.sof !== e.sof || o.eof !== e.eof || (e.eof && (o.err !== e.err || o.len !== e.len))) begin
        fail_count++;
        $display("FAIL bad_crc byte: got d=%h sof=%b eof=%b err=%b len=%0d, expected d=%h sof=%b eof=%b err=%b len=%0d",
                 o.d, o.sof, o.eof, o.err, o.len, e.d, e.sof, e.eof, e.err, e.len);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_drop();
    rec_t e, o;
    // Bad start byte, too-short preamble, and preamble-only burst: all silent.
    build_raw(10);
    send_frame(2, 8'hAA);
    idle(3);
    build_frame(60);
    send_frame(1, 8'hD5);
    idle(3);
    for (int i = 0; i < 5; i++) drive_byte(8'h55, i < 4);
    idle(3);
    cmp_count++;
    if (obs_q.size() !== 0) begin
      fail_count++;
      $display("FAIL drop_silent: got %0d pulses, expected 0", obs_q.size());
    end
    obs_q.delete();
    // Exactly the minimum preamble is accepted.
    build_frame(60);
    expect_frame(1'b0);
    send_frame(2, 8'hD5);
    idle(4);
    $display("drop: recovery frame %0d bytes in, %0d pulses out", frm.size(), obs_q.size());
    cmp_count++;
    if (obs_q.size() !== exp_q.size()) begin
      fail_count++;
      $display("FAIL drop_recover count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); cmp_count++;
      if (o.d !== e.d || o.sof !== e.sof || o.eof !== e.eof || (e.eof && (o.err !== e.err || o.len !== e.len))) begin
        fail_count++;
        $display("FAIL drop_recover byte: got d=%h sof=%b eof=%b err=%b len=%0d, expected d=%h sof=%b eof=%b err=%b len=%0d",
                 o.d, o.sof, o.eof, o.err, o.len, e.d, e.sof, e.eof, e.err, e.len);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_midframe();
    rec_t e, o;
    build_frame(60);
    for (int i = 0; i < 20 - HOLD_D; i++) exp_q.push_back('{frm[i], i == 0, 1'b0, 1'b0, 11'd0});
    for (int i = 0; i < 7; i++) drive_byte(8'h55, 1'b1);
    drive_byte(8'hD5, 1'b1);
    for (int i = 0; i < 20; i++) drive_byte(frm[i], 1'b1);
    reset = 1'b1;
    @(posedge mii_clk); #1;
    cmp_count++;
    if ({out_valid, out_sof, out_eof, out_err, frame_len} !== '0) begin
      fail_count++;
      $display("FAIL midreset_outputs: got valid=%b sof=%b eof=%b err=%b len=%0d, expected all 0",
               out_valid, out_sof, out_eof, out_err, frame_len);
    end
    reset = 1'b0;
    idle(6);
    $display("reset_midframe: %0d pulses before reset", obs_q.size());
    cmp_count++;
    if (obs_q.size() !== exp_q.size()) begin
      fail_count++;
      $display("FAIL midreset count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); cmp_count++;
      if (o.d !== e.d || o.sof !== e.sof || o.eof !== e.eof) begin
        fail_count++;
        $display("FAIL midreset byte: got d=%h sof=%b eof=%b, expected d=%h sof=%b eof=%b",
                 o.d, o.sof, o.eof, e.d, e.sof, e.eof);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_length();
    rec_t e, o;
    int   sizes[9] = '{36, 1514, 1515, 1596, 2049, -1, -4, -5, 60};
    for (int t = 0; t < 9; t++) begin
      if (sizes[t] < 0) build_raw(-sizes[t]);
      else              build_frame(sizes[t]);
      expect_frame(sizes[t] < 0);
      send_frame(7, 8'hD5);
      idle(4);
      $display("length: %0d bytes in, %0d pulses out", frm.size(), obs_q.size());
      cmp_count++;
      if (obs_q.size() !== exp_q.size()) begin
        fail_count++;
        $display("FAIL length_%0d count: got %0d, expected %0d", frm.size(), obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
        e = exp_q.pop_front(); o = obs_q.pop_front(); cmp_count++;
        if (o.d !== e.d || o.sof !== e.sof || o.eof !== e.eof || (e.eof && (o.err !== e.err || o.len !== e.len))) begin
          fail_count++;
          $display("FAIL length_%0d byte: got d=%h sof=%b eof=%b err=%b len=%0d, expected d=%h sof=%b eof=%b err=%b len=%0d",
                   frm.size(), o.d, o.sof, o.eof, o.err, o.len, e.d, e.sof, e.eof, e.err, e.len);
        end
      end
      exp_q.delete(); obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    build_frame(60);
    expect_frame(1'b0);
    send_frame(7, 8'hD5);
    build_frame(80);
    expect_frame(1'b0);
    send_frame(2, 8'hD5);
    idle(4);
    $display("back_to_back: %0d pulses out", obs_q.size());
    cmp_count++;
    if (obs_q.size() !== exp_q.size()) begin
      fail_count++;
      $display("FAIL back_to_back count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); cmp_count++;
      if (o.d !== e.d || o.sof !== e.sof || o.eof !== e.eof || (e.eof && (o.err !== e.err || o.len !== e.len))) begin
        fail_count++;
        $display("FAIL back_to_back byte: got d=%h sof=%b eof=%b err=%b len=%0d, expected d=%h sof=%b eof=%b err=%b len=%0d",
                 o.d, o.sof, o.eof, o.err, o.len, e.d, e.sof, e.eof, e.err, e.len);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_drop();
    test_reset_midframe();
    test_length();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
    $finish;
  end

endmodule
